// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based forwarding, stall, flush and freeze control for the 5-stage pipeline
module hazard_ctrl #(
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid_i,
  input  logic [4:0]       rs1_idx_d_i,
  input  logic [4:0]       rs2_idx_d_i,
  input  logic             rs1_used_d_i,
  input  logic             rs2_used_d_i,
  input  logic             branch_d_i,
  input  logic [4:0]       rd_idx_d_i,
  input  logic             reg_write_en_d_i,
  input  logic             is_load_d_i,
  input  logic             taken_d_i,
  input  logic             mem_busy_i,
  output logic             enable_o,
  output logic             bubble_o,
  output logic             flush_f_o,
  output logic             freeze_o,
  output logic             taken_ok_o,
  output logic             rs1_depended_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] STALL  = 2'd1;
  localparam logic [1:0] FREEZE = 2'd2;
  localparam int RW = $clog2(STALL_LIMIT + 1);
  localparam logic [RW-1:0] LIMIT = RW'(STALL_LIMIT);

  logic          s1_v, s2_v, s3_v;
  logic [4:0]    s1_rd, s2_rd, s3_rd;
  logic          s1_ld, s2_ld, s3_ld;
  logic [1:0]    state, next_state;
  logic [RW-1:0] run_len, run_nxt;
  logic          a1, a2, a3, b1, b2, b3;
  logic          load_stall, branch_stall, stall, entry_v;

  function automatic logic hit(input logic v, input logic [4:0] rd, input logic [4:0] rs, input logic used);
    return v & (rd == rs) & (rs != 5'd0) & used;
  endfunction

  // operand matches against each in-flight writer, then stall and forward decisions
  always_comb begin
    a1 = hit(s1_v, s1_rd, rs1_idx_d_i, rs1_used_d_i);
    a2 = hit(s2_v, s2_rd, rs1_idx_d_i, rs1_used_d_i);
    a3 = hit(s3_v, s3_rd, rs1_idx_d_i, rs1_used_d_i);
    b1 = hit(s1_v, s1_rd, rs2_idx_d_i, rs2_used_d_i);
    b2 = hit(s2_v, s2_rd, rs2_idx_d_i, rs2_used_d_i);
    b3 = hit(s3_v, s3_rd, rs2_idx_d_i, rs2_used_d_i);
    load_stall   = ((a1 | b1) & s1_ld) | ((a2 | b2) & s2_ld);
    branch_stall = branch_d_i & (a1 | b1);
    stall        = id_valid_i & (load_stall | branch_stall) & ~mem_busy_i;
    entry_v      = id_valid_i & reg_write_en_d_i & (rd_idx_d_i != 5'd0);
    fwd_rs1_sel_o = (a1 & ~s1_ld) ? 2'd1 : (a2 & ~s2_ld) ? 2'd2 : a3 ? 2'd3 : 2'd0;
    fwd_rs2_sel_o = (b1 & ~s1_ld) ? 2'd1 : (b2 & ~s2_ld) ? 2'd2 : b3 ? 2'd3 : 2'd0;
    rs1_depended_o = branch_d_i & (fwd_rs1_sel_o != 2'd0);
    freeze_o   = mem_busy_i;
    enable_o   = ~(stall | mem_busy_i);
    bubble_o   = stall;
    taken_ok_o = taken_d_i & id_valid_i & ~stall & ~mem_busy_i;
    flush_f_o  = taken_ok_o;
    next_state = mem_busy_i ? FREEZE : stall ? STALL : RUN;
    run_nxt    = (next_state != STALL) ? '0 : (state != STALL) ? RW'(1) :
                 (run_len == LIMIT) ? run_len : run_len + RW'(1);
  end

  // scoreboard shift: hold on freeze, insert an empty slot on bubble
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {s1_v, s2_v, s3_v}    <= '0;
      {s1_rd, s2_rd, s3_rd} <= '0;
      {s1_ld, s2_ld, s3_ld} <= '0;
    end else if (!mem_busy_i) begin
      {s3_v, s3_rd, s3_ld} <= {s2_v, s2_rd, s2_ld};
      {s2_v, s2_rd, s2_ld} <= {s1_v, s1_rd, s1_ld};
      {s1_v, s1_rd, s1_ld} <= {entry_v & ~stall, rd_idx_d_i, is_load_d_i};
    end
  end

  // run-state tracking, consecutive-stall watchdog and saturating stall counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      run_len     <= '0;
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state       <= next_state;
      run_len     <= run_nxt;
      err_o       <= err_o | (run_nxt == LIMIT);
      stall_cnt_o <= (stall && !(&stall_cnt_o)) ? stall_cnt_o + 1'b1 : stall_cnt_o;
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the five-stage MCU pipeline (IF, ID, EXE, MEM, WB); replaces the tied-high pipeline enable and tied-low rs1 dependence flag.
- Keeps a shadow scoreboard of in-flight writers in EXE, MEM and WB.
- Generates per-operand forwarding selects, load-use and branch-operand stalls, bubble insertion, fetch flush on taken redirect, and a global freeze while data memory is busy.
- Keeps a saturating stall counter and a sticky stall-watchdog error.

Parameters:
- STALL_LIMIT, 16: consecutive STALL cycles after which err_o sets.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID holds a valid instruction.
- rs1_idx_d_i  in  5  ID source register 1.
- rs2_idx_d_i  in  5  ID source register 2.
- rs1_used_d_i  in  1  ID instruction reads rs1.
- rs2_used_d_i  in  1  ID instruction reads rs2.
- branch_d_i  in  1  ID instruction resolves a branch or jump in ID.
- rd_idx_d_i  in  5  ID destination register.
- reg_write_en_d_i  in  1  ID instruction writes rd.
- is_load_d_i  in  1  ID instruction is a load.
- taken_d_i  in  1  ID redirect request.
- mem_busy_i  in  1  data memory not ready.
- enable_o  out  1  IF/ID register and PC advance enable.
- bubble_o  out  1  ID→EXE register loads a NOP.
- flush_f_o  out  1  IF/ID register loads a NOP.
- freeze_o  out  1  all pipeline registers hold.
- taken_ok_o  out  1  qualified redirect to IF.
- rs1_depended_o  out  1  branch rs1 needs forwarded or stalled data.
- fwd_rs1_sel_o  out  2  0 regfile, 1 EXE ALU result, 2 MEM ALU result, 3 WB write-back data.
- fwd_rs2_sel_o  out  2  same encoding for rs2.
- stall_cnt_o  out  CNT_W  total stall cycles, saturating.
- err_o  out  1  sticky watchdog error.

Behaviour:
- Scoreboard slots S1/S2/S3 mirror the instructions in EXE/MEM/WB. Each slot holds {v, rd, ld}.
- Normal clock edge: S3←S2, S2←S1, S1←ID entry. The ID entry is {id_valid_i & reg_write_en_d_i & rd≠0, rd_idx_d_i, is_load_d_i}.
- When bubble_o=1, S1 loads v=0 instead of the ID entry.
- When freeze_o=1, all slots hold.
- Match(rsX, Sk) = Sk.v & Sk.rd==rsX & rsX≠0 & rsX_used. x0 never matches.
- Forward select uses the youngest match first:
  - S1 non-load: sel 1.
  - else S2 non-load: sel 2.
  - else S3 any: sel 3.
  - else: sel 0.
- load_stall = a match on S1 or S2 with ld=1.
- branch_stall = branch_d_i & a match of either operand on S1. Branch compare in ID cannot take the EXE ALU result.
- stall = id_valid_i & (load_stall | branch_stall) & ~mem_busy_i.
- rs1_depended_o = branch_d_i & (fwd_rs1_sel_o≠0).
- freeze_o = mem_busy_i.
- enable_o = ~(stall | mem_busy_i).
- bubble_o = stall.
- taken_ok_o = taken_d_i & id_valid_i & ~stall & ~mem_busy_i.
- flush_f_o = taken_ok_o. A redirect raised during a stall is ignored until the stall clears.
- FSM states: RUN, STALL, FREEZE. Next state is evaluated every cycle:
  - mem_busy_i → FREEZE.
  - else stall → STALL.
  - else → RUN.
  - mem_busy_i has priority over any stall.
- Consecutive-stall counter: increments while in STALL; clears on any other state.
- err_o sets when the consecutive-stall counter reaches STALL_LIMIT. It clears only on reset.
- stall_cnt_o increments on each cycle with stall=1 and saturates at all-ones.
- Freeze cycles are not counted.
- Outputs are combinational from slots and inputs; no added latency.
- Load-use penalty:
  - 2 cycles for a dependent instruction right behind a load.
  - 1 cycle for a dependent instruction one instruction behind a load.
  - 1 cycle for a branch depending on an ALU op in EXE.
- Reset (async, resetn=0):
  - All slots v=0. FSM in RUN. Counters 0. err_o=0.
  - Outputs: enable_o=1, bubble_o=0, flush_f_o=0, freeze_o=0, taken_ok_o=0, fwd selects 0, rs1_depended_o=0.
- Reset mid-stall discards the scoreboard.

Test Plan:
- addi x5 then add x6,x5,x1 back-to-back → fwd_rs1_sel_o=1, no stall, stall_cnt_o stays 0.
- lw x5 then add x6,x5,x5 → 2 cycles with enable_o=0, bubble_o=1. Then fwd_rs1_sel_o=fwd_rs2_sel_o=3, stall_cnt_o=2.
- addi x7 then beq x7,x0 with taken_d_i=1 → 1 stall cycle with taken_ok_o=0. Next cycle: rs1_depended_o=1, fwd_rs1_sel_o=2, taken_ok_o=flush_f_o=1.
- Writer to x0 followed by a reader of x0 → all selects 0, no stall.
- mem_busy_i high 3 cycles during a load-use stall → freeze_o=1, bubble_o=0, slots and stall_cnt_o hold. The stall then resumes.
- Hold a load in S1 with mem_busy_i=0 and force slots static for 16 stall cycles → err_o=1, sticky. resetn pulse → err_o=0, enable_o=1.
